kalman_result_buffer: RTL and testbench
=======================================

Name: kalman_result_buffer

Overview:
- Sits directly upstream of the SPI parallel-to-serial stage.
- Accepts 16-bit Kalman filter estimates on a valid strobe and queues them in a small FIFO.
- Presents one word at a time to the serializer as filtered_data/filter_done.
- Holds each presented word frozen for the whole RPi SPI transaction (rpi_cs low), so the serializer never sees a mid-frame change.
- Advances to the next queued word only when a transaction ends (rpi_cs rising).

Parameters:
- DATA_W, 16: width of filter estimates and of filtered_data.
- DEPTH, 4: FIFO entries; must be a power of two, ≥2.
- SYNC_STAGES, 2: flip-flop stages synchronizing rpi_cs into clk; must be ≥2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  Kalman filter estimate.
- in_valid  input  1  single-cycle strobe; in_data is valid this cycle.
- in_ready  output  1  high when FIFO not full (registered status).
- rpi_cs  input  1  RPi SPI chip select, asynchronous to clk, active low.
- filtered_data  output  DATA_W  word currently presented to the serializer.
- filter_done  output  1  high while filtered_data holds an unconsumed word.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky; set when a word is dropped.

Behaviour:
- Reset values:
  - filtered_data=0, filter_done=0, fifo_level=0, overflow=0, in_ready=1.
  - FIFO pointers 0; state EMPTY.
  - All rpi_cs sync flops and the edge-detect flop reset to 1 (idle).
- CS sync:
  - cs_s is the rpi_cs value after SYNC_STAGES flops.
  - Fall = cs_s_prev & ~cs_s; rise = ~cs_s_prev & cs_s.
- FIFO push:
  - Push when in_valid & in_ready.
  - in_ready is !full from the registered count; a pop in the same cycle does not make room for a push while full.
  - in_valid while full: word dropped, FIFO unchanged, overflow set until rst.
- FIFO pop: occurs only on a state-machine load. Simultaneous push and pop leaves fifo_level unchanged. Pointers wrap modulo DEPTH.
- State EMPTY (filter_done=0; filtered_data keeps its last value):
  - If fifo_level>0, cs_s=1 and no fall this cycle: pop into filtered_data, go to LOADED.
  - A fall while EMPTY is an underrun: stay EMPTY and make no load until cs_s=1.
- State LOADED (filter_done=1): a fall moves to SHIFTING.
- State SHIFTING (filter_done=1; filtered_data frozen; pushes still accepted):
  - On rise, the word is consumed.
  - If fifo_level>0, pop the next word into filtered_data in that same cycle and go to LOADED; filter_done stays 1.
  - Else clear filter_done and go to EMPTY.
- Latency:
  - in_valid at cycle N into an empty FIFO with state EMPTY and cs_s=1: fifo_level=1 at N+1, filter_done=1 and filtered_data=word at N+2.
  - rpi_cs rise to next word presented: SYNC_STAGES+1 cycles.
- Reset mid-transaction: everything returns to its reset value immediately. If rpi_cs is still low, the resulting fall is treated as an underrun; no load occurs until rpi_cs returns high.
- Word order is strictly FIFO. No word is ever presented twice.

Optional Feature:
- Macro: KALMAN_RESULT_BUFFER_STATS_EN.
- When defined, adds output ports drop_cnt[7:0] and underrun_cnt[7:0], both reset to 0 and saturating at 255:
  - drop_cnt increments on each dropped push.
  - underrun_cnt increments on each fall seen in EMPTY.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single word: rpi_cs=1, in_data=16'h1234 with in_valid at cycle N → filter_done=1 and filtered_data=16'h1234 at N+2; fifo_level returns to 0.
- Freeze during frame:
  - Load 16'h1234, drive rpi_cs low, push 16'h5678 → filtered_data stays 16'h1234 and fifo_level=1 until rpi_cs rises.
  - 3 cycles after the rise: filtered_data=16'h5678, filter_done continuously 1.
- Overflow (DEPTH=4):
  - With rpi_cs held low after the first load, push 16'h0001..16'h0006 → 16'h0001 presented, 16'h0002..16'h0005 queued (fifo_level=4, in_ready=0); 16'h0006 dropped, overflow=1.
  - Successive frames then present 16'h0002..16'h0005 in order.
- Underrun: FIFO empty, pulse rpi_cs low/high → filter_done stays 0, no pop; underrun_cnt=1 with KALMAN_RESULT_BUFFER_STATS_EN defined.
- Simultaneous push/pop: fifo_level=2 in SHIFTING; rpi_cs rise timed so the pop cycle coincides with in_valid → fifo_level stays 2, FIFO order preserved.
- Reset mid-frame:
  - Assert rst during SHIFTING with rpi_cs low → next cycle all outputs are at their reset values.
  - No load until rpi_cs goes high.
  - A word pushed afterwards appears 2 cycles after its in_valid once cs_s=1.

Source files
------------

// File: rtl/kalman_result_buffer.sv
// Result FIFO that hands Kalman estimates to the SPI serializer, one per frame.
// Optional KALMAN_RESULT_BUFFER_STATS_EN adds drop/underrun counters.
module kalman_result_buffer #(
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    rpi_cs,
   output logic [DATA_W-1:0]       filtered_data,
   output logic                    filter_done,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic                    overflow
`ifdef KALMAN_RESULT_BUFFER_STATS_EN
   ,
   output logic [7:0]              drop_cnt,
   output logic [7:0]              underrun_cnt
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      LOADED   = 2'd1,
      SHIFTING = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic [SYNC_STAGES-1:0] cs_sync;
   logic                   cs_s;
   logic                   cs_prev;
   logic                   cs_fall;
   logic                   cs_rise;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   logic full;
   logic nonempty;
   logic push;
   logic drop;
   logic pop;
   logic underrun;

   // Sync chain idles high so reset never fabricates a CS edge
   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync <= '1;
         cs_prev <= 1'b1;
      end else begin
         cs_sync <= {cs_sync[SYNC_STAGES-2:0], rpi_cs};
         cs_prev <= cs_s;
      end
   end

   assign cs_s    = cs_sync[SYNC_STAGES-1];
   assign cs_fall = cs_prev & ~cs_s;
   assign cs_rise = ~cs_prev & cs_s;

   // Status comes from the registered level only
   assign full     = (fifo_level == LW'(DEPTH));
   assign nonempty = (fifo_level != '0);
   assign in_ready = ~full;
   assign push     = in_valid & ~full;
   assign drop     = in_valid & full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         EMPTY: begin
            if (nonempty && cs_s && !cs_fall) begin
               state_nx = LOADED;
            end
         end
         LOADED: begin
            if (cs_fall) begin
               state_nx = SHIFTING;
            end
         end
         SHIFTING: begin
            if (cs_rise) begin
               state_nx = nonempty ? LOADED : EMPTY;
            end
         end
         default: state_nx = EMPTY;
      endcase
   end

   always_comb begin
      pop         = 1'b0;
      underrun    = 1'b0;
      filter_done = 1'b0;
      unique case (state)
         EMPTY: begin
            pop      = nonempty & cs_s & ~cs_fall;
            underrun = cs_fall;
         end
         LOADED: begin
            filter_done = 1'b1;
         end
         SHIFTING: begin
            filter_done = 1'b1;
            pop         = cs_rise & nonempty;
         end
         default: begin
            filter_done = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_level    <= '0;
         overflow      <= 1'b0;
         filtered_data <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            filtered_data <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            fifo_level <= fifo_level + LW'(1);
         end else if (pop && !push) begin
            fifo_level <= fifo_level - LW'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

`ifdef KALMAN_RESULT_BUFFER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt     <= '0;
         underrun_cnt <= '0;
      end else begin
         if (drop && drop_cnt != 8'hff) begin
            drop_cnt <= drop_cnt + 8'd1;
         end
         if (underrun && underrun_cnt != 8'hff) begin
            underrun_cnt <= underrun_cnt + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_kalman_result_buffer.sv
// Directed bench for kalman_result_buffer: per-cycle vector table
// plus hand-written overflow, underrun, push/pop and reset sequences.
module tb_kalman_result_buffer;

   logic        clk;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        rpi_cs;
   logic [15:0] filtered_data;
   logic        filter_done;
   logic [2:0]  fifo_level;
   logic        overflow;
`ifdef KALMAN_RESULT_BUFFER_STATS_EN
   logic [7:0]  drop_cnt;
   logic [7:0]  underrun_cnt;
`endif

   int checks;
   int failures;

   kalman_result_buffer #(
      .DATA_W(16),
      .DEPTH(4),
      .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .rpi_cs(rpi_cs),
      .filtered_data(filtered_data),
      .filter_done(filter_done),
      .fifo_level(fifo_level),
      .overflow(overflow)
`ifdef KALMAN_RESULT_BUFFER_STATS_EN
      ,
      .drop_cnt(drop_cnt),
      .underrun_cnt(underrun_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [15:0] d;
      logic        cs;
      logic        done;
      logic [15:0] data;
      logic [2:0]  lvl;
   } vec_t;

   vec_t tbl [15];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input logic [15:0] d,
                       input logic cs);
      in_valid = v;
      in_data  = d;
      rpi_cs   = cs;
      @(posedge clk);
      #1;
   endtask

   task automatic cs_low3();
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0);
   endtask

   task automatic cs_high3();
      for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1);
   endtask

   task automatic chk_out(input string name, input logic done,
                          input logic [15:0] data, input logic [2:0] lvl);
      chk({name, ".done"}, 32'(filter_done), 32'(done));
      chk({name, ".data"}, 32'(filtered_data), 32'(data));
      chk({name, ".level"}, 32'(fifo_level), 32'(lvl));
   endtask

   task automatic chk_reset(input string name);
      chk_out(name, 1'b0, 16'h0, 3'd0);
      chk({name, ".ovf"}, 32'(overflow), 32'd0);
      chk({name, ".ready"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 16'h0;
      rpi_cs   = 1'b1;

      tbl[0]  = '{1'b1, 16'h1234, 1'b1, 1'b0, 16'h0000, 3'd1};
      tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 3'd0};
      tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 3'd0};
      tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 3'd0};
      tbl[4]  = '{1'b1, 16'h5678, 1'b0, 1'b1, 16'h1234, 3'd1};
      tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 3'd1};
      tbl[6]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 3'd1};
      tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 3'd1};
      tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h5678, 3'd0};
      tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h5678, 3'd0};
      tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h5678, 3'd0};
      tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h5678, 3'd0};
      tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h5678, 3'd0};
      tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h5678, 3'd0};
      tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h5678, 3'd0};

      step(1'b0, 16'h0, 1'b1);
      chk_reset("reset");
      rst = 1'b0;
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      chk_reset("idle");

      // single word, then a frame with a second word queued mid-frame
      for (int i = 0; i < 15; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].cs);
         chk_out($sformatf("vec%0d", i), tbl[i].done, tbl[i].data,
                 tbl[i].lvl);
         chk($sformatf("vec%0d.ready", i), 32'(in_ready), 32'd1);
         chk($sformatf("vec%0d.ovf", i), 32'(overflow), 32'd0);
      end

      // overflow
      step(1'b1, 16'h0001, 1'b1);
      step(1'b0, 16'h0000, 1'b1);
      chk_out("ovf.load", 1'b1, 16'h0001, 3'd0);
      cs_low3();
      for (int k = 2; k <= 6; k++) step(1'b1, 16'(k), 1'b0);
      step(1'b0, 16'h0, 1'b0);
      chk_out("ovf.full", 1'b1, 16'h0001, 3'd4);
      chk("ovf.ready", 32'(in_ready), 32'd0);
      chk("ovf.flag", 32'(overflow), 32'd1);
`ifdef KALMAN_RESULT_BUFFER_STATS_EN
      chk("ovf.drop_cnt", 32'(drop_cnt), 32'd1);
`endif
      for (int k = 2; k <= 5; k++) begin
         cs_high3();
         chk_out($sformatf("ovf.frame%0d", k), 1'b1, 16'(k), 3'(5 - k));
         chk($sformatf("ovf.ready%0d", k), 32'(in_ready), 32'd1);
         cs_low3();
      end
      cs_high3();
      chk_out("ovf.drain", 1'b0, 16'h0005, 3'd0);
      chk("ovf.sticky", 32'(overflow), 32'd1);

      rst = 1'b1;
      step(1'b0, 16'h0, 1'b1);
      rst = 1'b0;
      chk_reset("reset2");
      cs_high3();

      // underrun
      cs_low3();
      chk_out("unr.low", 1'b0, 16'h0, 3'd0);
      cs_high3();
      chk_out("unr.high", 1'b0, 16'h0, 3'd0);
`ifdef KALMAN_RESULT_BUFFER_STATS_EN
      chk("unr.cnt", 32'(underrun_cnt), 32'd1);
`endif

      // simultaneous push/pop
      step(1'b1, 16'h00a1, 1'b1);
      chk_out("pp.a", 1'b0, 16'h0, 3'd1);
      step(1'b1, 16'h00b2, 1'b1);
      chk_out("pp.b", 1'b1, 16'h00a1, 3'd1);
      step(1'b1, 16'h00c3, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      chk_out("pp.shift", 1'b1, 16'h00a1, 3'd2);
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      step(1'b1, 16'h00d4, 1'b1);
      chk_out("pp.same", 1'b1, 16'h00b2, 3'd2);
      cs_low3();
      cs_high3();
      chk_out("pp.c", 1'b1, 16'h00c3, 3'd1);
      cs_low3();
      cs_high3();
      chk_out("pp.d", 1'b1, 16'h00d4, 3'd0);
      cs_low3();
      cs_high3();
      chk_out("pp.end", 1'b0, 16'h00d4, 3'd0);

      // reset mid-frame
      step(1'b1, 16'h00e5, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      cs_low3();
      chk_out("rmf.shift", 1'b1, 16'h00e5, 3'd0);
      rst = 1'b1;
      step(1'b0, 16'h0, 1'b0);
      rst = 1'b0;
      chk_reset("rmf.rst");
      cs_low3();
      step(1'b1, 16'h00f6, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      step(1'b0, 16'h0, 1'b0);
      chk_out("rmf.hold", 1'b0, 16'h0, 3'd1);
`ifdef KALMAN_RESULT_BUFFER_STATS_EN
      chk("rmf.unr", 32'(underrun_cnt), 32'd1);
`endif
      step(1'b0, 16'h0, 1'b1);
      step(1'b0, 16'h0, 1'b1);
      chk_out("rmf.wait", 1'b0, 16'h0, 3'd1);
      step(1'b0, 16'h0, 1'b1);
      chk_out("rmf.load", 1'b1, 16'h00f6, 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
